// File: rtl/tx_audio_mem.sv
// TX sample FIFO: packs I/Q word pairs into a RAM and replays them at the interpolator rate.
// Optional per-underrun counter output enabled by defining TX_UNDERRUN_CTR_EN.
module tx_audio_mem #(
  parameter int unsigned DEPTH_LOG2  = 9,
  parameter int unsigned START_LEVEL = 256,
  parameter int unsigned LOW_WATER   = 128
) (
  input  logic                  adc_clk,
  input  logic                  rst,
  input  logic                  wr_stb,
  input  logic [15:0]           wr_data,
  input  logic                  flush,
  input  logic                  tx_req,
  output logic [15:0]           tx_i,
  output logic [15:0]           tx_q,
  output logic                  tx_valid,
  output logic                  srq,
  output logic [DEPTH_LOG2:0]   fill,
  output logic                  underrun,
`ifdef TX_UNDERRUN_CTR_EN
  output logic                  wr_ovfl,
  output logic [15:0]           underrun_cnt
`else
  output logic                  wr_ovfl
`endif
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FillMax  = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [DEPTH_LOG2:0] StartLvl = (DEPTH_LOG2 + 1)'(START_LEVEL);
  localparam logic [DEPTH_LOG2:0] LowLvl   = (DEPTH_LOG2 + 1)'(LOW_WATER);

  typedef enum logic {StPrime, StRun} state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   fill_q, fill_d;
  logic                  phase_q;
  logic [15:0]           stage_q;
  logic [31:0]           mem [Depth];

  logic full, empty, commit_ok, drop, pop, under;

  always_comb begin
    full      = (fill_q == FillMax);
    empty     = (fill_q == '0);
    commit_ok = wr_stb & phase_q & ~full & ~flush;
    drop      = wr_stb & phase_q & full & ~flush;
    // Pop decision uses the pre-edge fill, so a same-cycle commit is never visible to it.
    pop       = tx_req & (state_q == StRun) & ~empty & ~flush;
    under     = tx_req & (state_q == StRun) & empty & ~flush;
  end

  always_comb begin
    fill_d = fill_q;
    unique case ({commit_ok, pop})
      2'b10:   fill_d = fill_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   fill_d = fill_q - (DEPTH_LOG2 + 1)'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StPrime: if (fill_q >= StartLvl) state_d = StRun;
      StRun:   if (under) state_d = StPrime;
      default: state_d = StPrime;
    endcase
    if (flush) state_d = StPrime;
  end

  always_ff @(posedge adc_clk) begin
    if (rst) begin
      state_q  <= StPrime;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      phase_q  <= 1'b0;
      stage_q  <= '0;
      tx_i     <= '0;
      tx_q     <= '0;
      tx_valid <= 1'b0;
      underrun <= 1'b0;
      wr_ovfl  <= 1'b0;
      srq      <= 1'b1;
    end else begin
      state_q  <= state_d;
      tx_valid <= tx_req;
      underrun <= under;
      srq      <= (fill_q < LowLvl);
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        fill_q   <= '0;
        phase_q  <= 1'b0;
        wr_ovfl  <= 1'b0;
      end else begin
        if (wr_stb) begin
          if (!phase_q) stage_q <= wr_data;
          phase_q <= ~phase_q;
        end
        if (drop)      wr_ovfl  <= 1'b1;
        if (commit_ok) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
        if (pop)       rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
        fill_q <= fill_d;
      end
      if (tx_req) begin
        if (pop) begin
          {tx_i, tx_q} <= mem[rd_ptr_q];
        end else begin
          tx_i <= '0;
          tx_q <= '0;
        end
      end
    end
  end

  // Storage has no reset; contents are only observed after a commit.
  always_ff @(posedge adc_clk) begin
    if (!rst && commit_ok) mem[wr_ptr_q] <= {stage_q, wr_data};
  end

  assign fill = fill_q;

`ifdef TX_UNDERRUN_CTR_EN
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      underrun_cnt <= '0;
    end else if (under && underrun_cnt != 16'hFFFF) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tx_audio_mem.sv
// Scoreboard bench for tx_audio_mem: a queue model predicts each tx_valid beat,
// fill, srq and wr_ovfl cycle by cycle.
module tb_tx_audio_mem;

  localparam int DEPTH = 512;
  localparam int START = 256;
  localparam int LOW   = 128;

  logic        adc_clk;
  logic        rst;
  logic        wr_stb;
  logic [15:0] wr_data;
  logic        flush;
  logic        tx_req;
  logic [15:0] tx_i, tx_q;
  logic        tx_valid, srq, underrun, wr_ovfl;
  logic [9:0]  fill;
`ifdef TX_UNDERRUN_CTR_EN
  logic [15:0] underrun_cnt;
`endif

  tx_audio_mem dut (
    .adc_clk     (adc_clk),
    .rst         (rst),
    .wr_stb      (wr_stb),
    .wr_data     (wr_data),
    .flush       (flush),
    .tx_req      (tx_req),
    .tx_i        (tx_i),
    .tx_q        (tx_q),
    .tx_valid    (tx_valid),
    .srq         (srq),
    .fill        (fill),
    .underrun    (underrun),
`ifdef TX_UNDERRUN_CTR_EN
    .wr_ovfl     (wr_ovfl),
    .underrun_cnt(underrun_cnt)
`else
    .wr_ovfl     (wr_ovfl)
`endif
  );

  initial adc_clk = 1'b0;
  always #5 adc_clk = ~adc_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] mq[$];
  logic [32:0] sb[$];
  bit          m_run, m_phase, m_ovfl, m_srq;
  logic [15:0] m_stage, m_ucnt;
  logic [15:0] last_i, last_q;
  int          v_seen, u_seen, u_idx;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic compare_outputs();
    logic [32:0] e;
    if (tx_valid) begin
      v_seen++;
      if (underrun) begin
        u_seen++;
        u_idx = v_seen;
      end
      if (sb.size() == 0) begin
        check_eq("unexpected_valid", 32'(tx_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("tx_i", 32'(tx_i), 32'(e[31:16]));
        check_eq("tx_q", 32'(tx_q), 32'(e[15:0]));
        check_eq("underrun", 32'(underrun), 32'(e[32]));
        last_i = e[31:16];
        last_q = e[15:0];
      end
    end else begin
      if (sb.size() != 0) begin
        check_eq("missing_valid", 32'(tx_valid), 32'd1);
        void'(sb.pop_front());
      end
      check_eq("underrun_idle", 32'(underrun), 32'd0);
      check_eq("hold_i", 32'(tx_i), 32'(last_i));
      check_eq("hold_q", 32'(tx_q), 32'(last_q));
    end
    check_eq("fill", 32'(fill), 32'(mq.size()));
    check_eq("srq", 32'(srq), 32'(m_srq));
    check_eq("wr_ovfl", 32'(wr_ovfl), 32'(m_ovfl));
`ifdef TX_UNDERRUN_CTR_EN
    check_eq("underrun_cnt", 32'(underrun_cnt), 32'(m_ucnt));
`endif
  endtask

  task automatic cycle(input bit w, input logic [15:0] d, input bit fl, input bit rq);
    int          sz;
    bit          pop, und;
    logic [31:0] p;
    rst = 1'b0; wr_stb = w; wr_data = d; flush = fl; tx_req = rq;
    sz  = mq.size();
    pop = rq && m_run && sz > 0 && !fl;
    und = rq && m_run && sz == 0 && !fl;
    p   = '0;
    if (pop) p = mq.pop_front();
    if (rq) sb.push_back({und, p});
    m_srq = (sz < LOW);
    if (und && m_ucnt != 16'hFFFF) m_ucnt++;
    if (fl) begin
      mq.delete();
      m_phase = 0; m_ovfl = 0; m_run = 0;
    end else begin
      if (w) begin
        if (!m_phase) begin
          m_stage = d; m_phase = 1;
        end else begin
          m_phase = 0;
          if (sz == DEPTH) m_ovfl = 1;
          else mq.push_back({m_stage, d});
        end
      end
      if (und) m_run = 0;
      else if (!m_run && sz >= START) m_run = 1;
    end
    @(posedge adc_clk); #1;
    compare_outputs();
  endtask

  task automatic do_reset();
    // Mid-pair write and tx_req alongside rst must both be ignored.
    rst = 1'b1; wr_stb = 1'b1; wr_data = 16'hDEAD; flush = 1'b0; tx_req = 1'b1;
    @(posedge adc_clk); #1;
    rst = 1'b0; wr_stb = 1'b0; tx_req = 1'b0;
    mq.delete(); sb.delete();
    m_run = 0; m_phase = 0; m_ovfl = 0; m_srq = 1;
    last_i = '0; last_q = '0;
    check_eq("rst_valid", 32'(tx_valid), 32'd0);
    check_eq("rst_fill", 32'(fill), 32'd0);
    check_eq("rst_srq", 32'(srq), 32'd1);
    check_eq("rst_ovfl", 32'(wr_ovfl), 32'd0);
    check_eq("rst_underrun", 32'(underrun), 32'd0);
    check_eq("rst_tx", {tx_i, tx_q}, 32'd0);
  endtask

  task automatic write_pairs(input int n, input int base);
    logic [15:0] v;
    for (int k = 0; k < n; k++) begin
      v = 16'(base + k);
      cycle(1, v, 0, 0);
      cycle(1, ~v, 0, 0);
    end
  endtask

  initial begin
    logic [15:0] v;
    rst = 1'b1; wr_stb = 0; wr_data = 0; flush = 0; tx_req = 0;
    m_ucnt = '0; v_seen = 0; u_seen = 0; u_idx = 0;
    repeat (2) @(posedge adc_clk);
    #1;
    do_reset();

    // Priming with tx_req every 8 cycles while writing.
    for (int c = 0; c < 512; c++) begin
      v = 16'(c / 2);
      cycle(1, (c % 2 == 1) ? ~v : v, 0, (c % 8) == 7);
    end
    for (int c = 0; c < 64; c++) cycle(0, 16'h0, 0, (c % 8) == 7);

    // Underrun after draining 256 pairs.
    do_reset();
    m_ucnt = '0;
    write_pairs(256, 0);
    cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
    v_seen = 0; u_seen = 0; u_idx = 0;
    for (int k = 0; k < 257; k++) begin
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 0);
    end
    check_eq("uflow_count", 32'(u_seen), 32'd1);
    check_eq("uflow_index", 32'(u_idx), 32'd257);
    check_eq("valid_count", 32'(v_seen), 32'd257);
    write_pairs(1, 16'h00AA);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    check_eq("prime_after_uflow", {tx_i, tx_q}, 32'd0);

    // Overflow: 513th pair is dropped.
    do_reset();
    write_pairs(513, 0);
    check_eq("ovfl_fill", 32'(fill), 32'd512);
    check_eq("ovfl_flag", 32'(wr_ovfl), 32'd1);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    check_eq("ovfl_first_pop", {tx_i, tx_q}, 32'h0000FFFF);
    for (int k = 0; k < 512; k++) begin
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 1);
    end
    check_eq("ovfl_pair512_absent", 32'(underrun), 32'd1);

    // Commit and pop in the same cycle.
    do_reset();
    write_pairs(300, 0);
    cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
    cycle(1, 16'hAAAA, 0, 0);
    cycle(1, 16'h5555, 0, 1);
    check_eq("simul_fill", 32'(fill), 32'd300);
    check_eq("simul_pop", {tx_i, tx_q}, 32'h0000FFFF);

    // Flush mid-pair, with a coincident tx_req.
    do_reset();
    cycle(1, 16'h1111, 0, 0);
    cycle(0, 0, 1, 1);
    check_eq("flush_valid", 32'(tx_valid), 32'd1);
    cycle(1, 16'h1234, 0, 0);
    cycle(1, 16'h5678, 0, 0);
    check_eq("flush_fill", 32'(fill), 32'd1);
    write_pairs(255, 16'h0100);
    cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    check_eq("flush_pair", {tx_i, tx_q}, 32'h12345678);

    // Reset in RUN at fill 200.
    do_reset();
    write_pairs(256, 0);
    cycle(0, 0, 0, 0); cycle(0, 0, 0, 0);
    for (int k = 0; k < 56; k++) begin
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 0);
    end
    check_eq("pre_rst_fill", 32'(fill), 32'd200);
    do_reset();
    cycle(0, 0, 0, 1);
    check_eq("post_rst_zero", {tx_i, tx_q}, 32'd0);

    // Random mixed traffic.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      cycle($urandom_range(0, 99) < 60, 16'($urandom), $urandom_range(0, 299) == 0,
            $urandom_range(0, 99) < 30);
    end
    cycle(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
